// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the EX-stage control and the sequential divider.
// Divide-op selection codes default here unless the ALU control unit already defines them.
`ifndef ALU_DIV
`define ALU_DIV  5'd10
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd11
`endif
`ifndef ALU_REM
`define ALU_REM  5'd12
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd13
`endif

interface seq_divider_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alu_sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic            stall;
  logic [XLEN-1:0] result;

  modport master (
    output start, alu_sel, op_a, op_b, flush,
    input  busy, done, stall, result
  );

  modport slave (
    input  start, alu_sel, op_a, op_b, flush,
    output busy, done, stall, result
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; XLEN cycles per op, 1 cycle for b==0/overflow.
// Holds the pipeline via stall from accept until the done cycle; flush or reset drop the op silently.
module seq_divider #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic            is_div_op;
  logic            op_signed;
  logic            op_rem;
  logic            accept;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            overflow;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            rem_op_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] res_calc;

  // Operation decode and operand conditioning at accept time.
  always_comb begin
    op_signed = (bus.alu_sel == `ALU_DIV)  || (bus.alu_sel == `ALU_REM);
    op_rem    = (bus.alu_sel == `ALU_REM)  || (bus.alu_sel == `ALU_REMU);
    is_div_op = op_signed || (bus.alu_sel == `ALU_DIVU) || (bus.alu_sel == `ALU_REMU);
    accept    = (state == IDLE) && bus.start && is_div_op;

    a_neg     = op_signed && bus.op_a[XLEN-1];
    b_neg     = op_signed && bus.op_b[XLEN-1];
    a_abs     = a_neg ? (-bus.op_a) : bus.op_a;
    b_abs     = b_neg ? (-bus.op_b) : bus.op_b;

    div_zero  = (bus.op_b == '0);
    overflow  = op_signed && (bus.op_a == INT_MIN) && (bus.op_b == '1);
    fast      = div_zero || overflow;

    // Architecturally defined results: no trap, no iteration needed.
    if (div_zero) begin
      fast_res = op_rem ? bus.op_a : '1;
    end else begin
      fast_res = op_rem ? '0 : bus.op_a;
    end
  end

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    q_bit    = ~diff[XLEN];
    rem_nxt  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_nxt  = {quo_q[XLEN-2:0], q_bit};

    if (rem_op_q) begin
      res_calc = neg_rem_q ? (-rem_nxt) : rem_nxt;
    end else begin
      res_calc = neg_quo_q ? (-quo_nxt) : quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.stall = 1'b0;

    case (state)
      IDLE: begin
        bus.stall = accept;
        if (accept) begin
          state_nxt = fast ? DONE : CALC;
        end
      end
      CALC: begin
        bus.busy  = 1'b1;
        bus.stall = 1'b1;
        if (cnt_q == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A flush beats both completion and a same-cycle accept.
    if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      rem_op_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        rem_q     <= '0;
        quo_q     <= a_abs;
        dvs_q     <= b_abs;
        cnt_q     <= CNT_LOAD;
        rem_op_q  <= op_rem;
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        if (fast) begin
          result_q <= fast_res;
        end
      end else if (state == CALC) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_q <= res_calc;
        end
      end
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results queued at issue, checked when done pulses.
`ifndef ALU_DIV
`define ALU_DIV  5'd10
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd11
`endif
`ifndef ALU_REM
`define ALU_REM  5'd12
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd13
`endif

module tb_seq_divider;

  localparam logic [4:0] DIV  = `ALU_DIV;
  localparam logic [4:0] DIVU = `ALU_DIVU;
  localparam logic [4:0] REM  = `ALU_REM;
  localparam logic [4:0] REMU = `ALU_REMU;
  localparam logic [4:0] ADD  = 5'd0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       tag;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  logic [31:0] last_res = 32'd0;
  exp_t  sb[$];
  exp_t  mon_e;

  seq_divider_if #(.XLEN(32)) bus ();

  seq_divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      chk("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_result"}, bus.result, mon_e.res);
        chk({mon_e.tag, "_latency"}, 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic drive(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.alu_sel = sel;
    bus.op_a    = a;
    bus.op_b    = b;
    bus.start   = 1'b1;
  endtask

  task automatic run(input string tag, input logic [4:0] sel, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res, input int lat,
                     input int pulse_at);
    exp_t e;
    int   n;
    int   stalls;
    bit   got;
    @(negedge clk);
    drive(sel, a, b);
    n     = cyc;
    e.res = exp_res;
    e.cyc = n + lat;
    e.tag = tag;
    sb.push_back(e);
    #1;
    chk({tag, "_stall_accept"}, 32'(bus.stall), 32'd1);
    stalls = 1;
    got    = 1'b0;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      bus.start = (i == pulse_at);
      if (i == pulse_at) begin
        bus.alu_sel = DIVU;
        bus.op_a    = 32'd100;
        bus.op_b    = 32'd7;
      end
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      stalls += int'(bus.stall);
    end
    bus.start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(lat));
    last_res = exp_res;
  endtask

  initial begin
    int n;
    bus.start   = 1'b0;
    bus.alu_sel = ADD;
    bus.op_a    = 32'd0;
    bus.op_b    = 32'd0;
    bus.flush   = 1'b0;

    @(negedge clk);
    chk("reset_busy",   32'(bus.busy),  32'd0);
    chk("reset_done",   32'(bus.done),  32'd0);
    chk("reset_stall",  32'(bus.stall), 32'd0);
    chk("reset_result", bus.result,     32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14, 33, -1);
    run("remu_100_7", REMU, 32'd100, 32'd7, 32'd2,  33, -1);
    run("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, -1);
    run("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, -1);
    run("divu_5_0",   DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1);
    run("rem_5_0",    REM,  32'd5, 32'd0, 32'd5, 1, -1);
    run("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1);
    run("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, -1);
    run("div_100_m7", DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, -1);
    run("rem_100_m7", REM,  32'd100, 32'hFFFF_FFF9, 32'd2, 33, -1);
    run("div_m8_m3",  DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33, -1);
    run("rem_m8_m3",  REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, -1);
    run("remu_max_16", REMU, 32'hFFFF_FFFF, 32'd16, 32'd15, 33, -1);
    run("divu_max_1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, -1);
    run("remu_min_m1", REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, -1);
    run("div_restart_ignored", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 5);
    repeat (3) @(negedge clk);

    // Non-divide selection must not be taken.
    drive(ADD, 32'd100, 32'd7);
    #1;
    chk("nondiv_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("nondiv_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);

    // Flush mid-iteration: no done, result untouched.
    drive(DIVU, 32'd100, 32'd7);
    n = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < n + 10) @(negedge clk);
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy_after",  32'(bus.busy),  32'd0);
    chk("flush_stall_after", 32'(bus.stall), 32'd0);
    chk("flush_result_held", bus.result,     last_res);
    repeat (40) @(negedge clk);
    run("divu_9_3_after_flush", DIVU, 32'd9, 32'd3, 32'd3, 33, -1);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-iteration.
    drive(DIVU, 32'd100, 32'd7);
    n = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < n + 10) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),  32'd0);
    chk("arst_stall",  32'(bus.stall), 32'd0);
    chk("arst_done",   32'(bus.done),  32'd0);
    chk("arst_result", bus.result,     32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst_no_resume", bus.result, 32'd0);
    run("divu_9_3_after_reset", DIVU, 32'd9, 32'd3, 32'd3, 33, -1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
